// File: rtl/reg_mem_pkg.sv
// Shared types and constants for the multi-read-port register memory.
package reg_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int RD_FIRST   = 0;
    localparam int WR_THROUGH = 1;

endpackage

// File: rtl/reg_mem_clr_fsm.sv
// Clear engine: sweeps every address to zero, one per cycle, and flags busy.
module reg_mem_clr_fsm
    import reg_mem_pkg::*;
#(
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    output logic                 busy,
    output logic                 clr_we,
    output logic [ADDR_BITS-1:0] clr_addr
);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + ADDR_BITS'(1);
                // The counter wraps to zero on the same edge the sweep ends.
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_mem_mp.sv
// Register memory with one write port, NUM_RD registered read ports and a clear sweep.
module reg_mem_mp
    import reg_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int NUM_RD     = 2,
    parameter int RD_MODE    = RD_FIRST
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen,
    input  logic [ADDR_BITS-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [NUM_RD-1:0]            ren,
    input  logic [NUM_RD*ADDR_BITS-1:0]  raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] data_out,
    input  logic                         clr,
    output logic                         busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  clr_we;
    logic [ADDR_BITS-1:0]  clr_addr;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    reg_mem_clr_fsm #(
        .ADDR_BITS (ADDR_BITS)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The sweep owns the write port while running; reset blocks every write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = data_in;
        if (!rst) begin
            if (clr_we) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
            end else begin
                mem_we = wen;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto plain storage; only the read registers reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_BITS-1:0]  rd_addr;
        logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

        assign rd_addr = raddr[k*ADDR_BITS +: ADDR_BITS];

        // Reading the array before the edge gives read-first naturally; write-through bypasses.
        always_comb begin
            rd_data_d = rd_data_q;
            if (ren[k]) begin
                rd_data_d = mem_q[rd_addr];
                if (RD_MODE == WR_THROUGH && mem_we && mem_waddr == rd_addr) begin
                    rd_data_d = mem_wdata;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
    end

endmodule

// File: tb/tb_reg_mem_mp.sv
// Randomized and directed bench for reg_mem_mp; both collision modes run side by side.
module tb_reg_mem_mp;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst, wen, clr;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     data_in;
    logic [NR-1:0]     ren;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  dout_rf, dout_wt;
    logic              busy_rf, busy_wt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain array, expected read registers and sweep position (-1 = idle).
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rf  [NR];
    logic [DW-1:0] exp_wt  [NR];
    int            sweep_idx = -1;

    always #5 clk = ~clk;

    reg_mem_mp #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .NUM_RD(NR), .RD_MODE(0)) u_dut_rf (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .data_in(data_in),
        .ren(ren), .raddr(raddr), .data_out(dout_rf), .clr(clr), .busy(busy_rf)
    );

    reg_mem_mp #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .NUM_RD(NR), .RD_MODE(1)) u_dut_wt (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .data_in(data_in),
        .ren(ren), .raddr(raddr), .data_out(dout_wt), .clr(clr), .busy(busy_wt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge using the current inputs, then compare after the edge.
    task automatic tick();
        logic          we;
        int            wa, ra;
        logic [DW-1:0] wd;
        if (rst) begin
            for (int k = 0; k < NR; k++) begin
                exp_rf[k] = '0;
                exp_wt[k] = '0;
            end
            sweep_idx = -1;
        end else begin
            if (sweep_idx >= 0) begin
                we = 1'b1; wa = sweep_idx; wd = '0;
            end else begin
                we = wen; wa = int'(waddr); wd = data_in;
            end
            for (int k = 0; k < NR; k++) begin
                if (ren[k]) begin
                    ra = int'(raddr[k*AW +: AW]);
                    exp_rf[k] = ref_mem[ra];
                    exp_wt[k] = (we && ra == wa) ? wd : ref_mem[ra];
                end
            end
            if (we) ref_mem[wa] = wd;
            if (sweep_idx >= 0) begin
                sweep_idx++;
                if (sweep_idx == DEPTH) sweep_idx = -1;
            end else if (clr) begin
                sweep_idx = 0;
            end
        end
        @(posedge clk);
        #1;
        check("busy_rf", 32'(busy_rf), 32'(sweep_idx >= 0));
        check("busy_wt", 32'(busy_wt), 32'(sweep_idx >= 0));
        for (int k = 0; k < NR; k++) begin
            check($sformatf("dout_rf[%0d]", k), 32'(dout_rf[k*DW +: DW]), 32'(exp_rf[k]));
            check($sformatf("dout_wt[%0d]", k), 32'(dout_wt[k*DW +: DW]), 32'(exp_wt[k]));
        end
    endtask

    task automatic write(input int a, input int d);
        wen = 1'b1; waddr = AW'(a); data_in = DW'(d);
        tick();
        wen = 1'b0;
    endtask

    task automatic read2(input int a0, input int a1);
        ren = '1; raddr = {AW'(a1), AW'(a0)};
        tick();
        ren = '0;
    endtask

    task automatic fill(input int d);
        for (int i = 0; i < DEPTH; i++) write(i, d);
    endtask

    task automatic read_all_expect(input string tag, input int lo_end, input int lo_val, input int hi_val);
        for (int i = 0; i < DEPTH; i++) begin
            read2(i, i);
            check(tag, 32'(dout_rf[DW-1:0]), (i < lo_end) ? lo_val : hi_val);
        end
    endtask

    // Runs a sweep from a one-cycle clr pulse; an optional second pulse lands at busy cycle repulse_at.
    task automatic sweep_and_count(input string tag, input int repulse_at);
        int n;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n = busy_rf ? 1 : 0;
        for (int guard = 0; guard < 64 && busy_rf; guard++) begin
            if (n == 2) begin
                wen = 1'b1; waddr = AW'(3); data_in = 8'h55;
            end
            if (n == repulse_at) clr = 1'b1;
            tick();
            wen = 1'b0; clr = 1'b0;
            if (busy_rf) n++;
        end
        check(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        int hold_val;
        rst = 1'b1; wen = 1'b0; clr = 1'b0; ren = '0; raddr = '0; waddr = '0; data_in = '0;
        tick();
        check("reset_dout", 32'(dout_rf), 32'h0);
        rst = 1'b0;

        // Fill and read with opposing address patterns on the two ports.
        for (int i = 0; i < DEPTH; i++) write(i, i);
        for (int i = 0; i < DEPTH; i++) begin
            read2(i, DEPTH - 1 - i);
            check("fill_p0", 32'(dout_rf[DW-1:0]), 32'(i));
            check("fill_p1", 32'(dout_wt[2*DW-1:DW]), 32'(DEPTH - 1 - i));
        end

        // Same-address collision.
        write(5, 8'h11);
        wen = 1'b1; waddr = AW'(5); data_in = 8'hAA; ren = 2'b01; raddr = {AW'(0), AW'(5)};
        tick();
        wen = 1'b0; ren = '0;
        check("coll_read_first", 32'(dout_rf[DW-1:0]), 32'h11);
        check("coll_write_thru", 32'(dout_wt[DW-1:0]), 32'hAA);
        read2(5, 5);
        check("coll_after_rf", 32'(dout_rf[DW-1:0]), 32'hAA);
        check("coll_after_wt", 32'(dout_wt[DW-1:0]), 32'hAA);

        // Full clear sweep with a dropped write during busy.
        fill(8'hFF);
        sweep_and_count("sweep_len", -1);
        read_all_expect("swept_zero", DEPTH, 0, 0);

        // Hold while the addressed word changes, then reset keeps the array.
        write(7, 8'h3C);
        read2(7, 7);
        hold_val = 8'h3C;
        for (int c = 0; c < 5; c++) begin
            hold_val = 8'h40 + c;
            write(7, hold_val);
            check("hold_dout", 32'(dout_rf), 32'h3C3C);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_dout_rf", 32'(dout_rf), 32'h0);
        check("rst_dout_wt", 32'(dout_wt), 32'h0);
        read2(7, 7);
        check("post_rst_keep", 32'(dout_rf[DW-1:0]), 32'(hold_val));

        // Reset on the 10th busy cycle aborts the sweep after entries 0..8.
        fill(8'hFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy_rf), 32'h0);
        read_all_expect("abort_mem", 9, 0, 8'hFF);

        // A second clr at busy cycle 20 must not extend the sweep.
        sweep_and_count("reclr_len", 20);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            clr     = ($urandom_range(0, 79) == 0);
            wen     = $urandom_range(0, 1);
            waddr   = AW'($urandom);
            data_in = DW'($urandom);
            ren     = NR'($urandom);
            raddr   = (c % 4 == 0) ? {waddr, waddr} : (NR*AW)'($urandom);
            tick();
        end
        rst = 1'b0; clr = 1'b0; wen = 1'b0; ren = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_mem_mp.md
Name: reg_mem_mp

Overview:
Multi-read-port successor to the single-port register memory.
- One synchronous write port and NUM_RD independent registered read ports.
- Selectable read-during-write behaviour.
- Built-in clear engine that sweeps every entry to zero, one entry per cycle, under a busy flag.
- Used as a general-purpose small register file and scratch store in datapath blocks.

Parameters:
DATA_WIDTH, 8, width of each word in bits
ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS entries
NUM_RD, 2, number of independent read ports (1..4)
RD_MODE, 0, same-address collision policy: 0 = read-first (return old data), 1 = write-through (return new data)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
wen  in  1  write enable
waddr  in  ADDR_BITS  write address
data_in  in  DATA_WIDTH  write data
ren  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_BITS  packed read addresses; port k uses slice [k*ADDR_BITS +: ADDR_BITS]
data_out  out  NUM_RD*DATA_WIDTH  packed registered read data; port k uses slice [k*DATA_WIDTH +: DATA_WIDTH]
clr  in  1  start a clear sweep (level sampled on the edge)
busy  out  1  high while the clear sweep is running

Behaviour:
- Reset (rst=1 at an edge):
  - data_out goes to all-zero, busy=0, FSM goes to IDLE, sweep counter goes to 0.
  - Memory array is NOT reset.
  - rst has priority over every other input.
- Write, IDLE state: wen=1 writes mem[waddr]=data_in at the edge.
- Write, CLEAR state: wen is ignored and the write is silently dropped; no error flag.
- Read:
  - ren[k]=1 at edge N: slice k of data_out holds the read word after edge N, so latency is 1 cycle.
  - ren[k]=0: slice k holds its previous value.
  - Ports are fully independent; any ports may share an address.
- Collision (a read port and the active write target the same address in the same cycle, including the clear-engine write):
  - RD_MODE=0: read returns the pre-write contents.
  - RD_MODE=1: read returns the value being written (data_in, or 0 during clear).
- FSM states are IDLE and CLEAR.
  - IDLE, clr=1 -> CLEAR. Counter=0, busy=1 after that edge. No entry is cleared on the start edge; wen in that same cycle is still honoured.
  - CLEAR, each edge: mem[cnt]=0 and cnt increments.
  - CLEAR, at cnt==DEPTH-1: clear the final entry, return to IDLE, busy=0 after that edge.
  - busy is therefore high for exactly DEPTH consecutive cycles.
- clr while busy=1 is ignored; the sweep does not restart.
- Counter is ADDR_BITS wide; wrap at DEPTH-1 is intentional and coincides with the exit from CLEAR.
- Reset mid-sweep aborts the sweep immediately:
  - busy=0 after that edge.
  - Entries already swept stay 0; the rest keep their old contents.
- Reads during CLEAR are served normally, with the collision rule applied against the clear write.
- Address widths are exact, so no out-of-range addresses are possible.

Decomposition:
- Package reg_mem_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR);
  - RD_MODE constants RD_FIRST=0 and WR_THROUGH=1.
- One sub-module, reg_mem_clr_fsm:
  - contains the state register, sweep counter and busy flag;
  - outputs clr_we and clr_addr to the array write mux.
- Array, write mux and read ports stay in the top level; read ports are built with a generate loop over NUM_RD.

Test Plan:
- Fill and read: write i to address i for i=0..31, then read with port0 raddr=i and port1 raddr=31-i -> one cycle later port0=i and port1=31-i for every i.
- Collision: mem[5]=0x11, then in one cycle wen=1, waddr=5, data_in=0xAA, ren[0]=1, raddr0=5 -> data_out0=0x11 with RD_MODE=0, 0xAA with RD_MODE=1; the next read returns 0xAA in both modes.
- Clear sweep: fill with 0xFF, pulse clr for one cycle -> busy high for exactly 32 cycles. A write of 0x55 to address 3 during busy is dropped. After busy falls, all 32 addresses read 0x00.
- Hold and reset:
  - ren=0 for 5 cycles while the addressed data changes -> data_out unchanged.
  - Assert rst -> data_out=0 after that edge.
  - Contents written before reset still read back afterwards.
- Reset mid-sweep: fill with 0xFF, clr, assert rst on the 10th busy cycle -> busy=0 after that edge; addresses 0..8 read 0x00 and 9..31 read 0xFF.
- Clr while busy: a second clr pulse at busy cycle 20 -> busy still falls exactly 32 cycles after the first pulse.
